mem_fill_responder: RTL and testbench

- Pipelined, fixed-latency word memory; the responder end of the cache-fill read protocol.
- Accepts one request per cycle: a read or a write.
- Returns each read's data with a one-cycle data_valid pulse exactly LATENCY cycles after issue.
- Sits between the instruction/data cache fill FSMs and main-memory storage. Back-to-back 8-word line fills stream out as 8 consecutive valid beats.

---
 rtl/mem_fill_responder.sv | 84 ++++++++
 tb/tb_mem_fill_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_fill_responder.sv
// Fixed-latency pipelined word memory answering cache-fill reads.
// Reads sample storage at issue and return through a LATENCY-deep valid/data shift pipeline.
module mem_fill_responder #(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       data_in,
    output logic [15:0]       data_out,
    output logic              data_valid,
    output logic [3:0]        pending
);

    localparam int DEPTH = 1 << (ADDR_W - 1);

    logic [15:0]       r_mem [DEPTH];
    logic [ADDR_W-2:0] w_word_idx;
    logic [15:0]       w_rd_word;
    logic              w_rd_issue;
    logic              w_wr_issue;

    logic [LATENCY-1:0] w_vld;
    logic [LATENCY-1:0] w_vld_in;
    logic [15:0]        w_dat    [LATENCY];
    logic [15:0]        w_dat_in [LATENCY];
    logic [3:0]         w_count;

    assign w_word_idx = addr[ADDR_W-1:1];
    assign w_rd_word  = r_mem[w_word_idx];
    assign w_rd_issue = enable & ~wr;
    // Writes are dropped while reset is held so requests during reset have no effect.
    assign w_wr_issue = enable & wr & rst_n;

    always_ff @(posedge clk) begin
        if (w_wr_issue) begin
            r_mem[w_word_idx] <= data_in;
        end
    end

    assign w_vld_in[0] = w_rd_issue;
    assign w_dat_in[0] = w_rd_issue ? w_rd_word : 16'h0000;

    generate
        for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
            logic        r_v;
            logic [15:0] r_d;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_v <= 1'b0;
                    r_d <= 16'h0000;
                end else begin
                    r_v <= w_vld_in[gi];
                    r_d <= w_dat_in[gi];
                end
            end

            assign w_vld[gi] = r_v;
            assign w_dat[gi] = r_d;

            if (gi > 0) begin : g_link
                assign w_vld_in[gi] = w_vld[gi-1];
                assign w_dat_in[gi] = w_dat[gi-1];
            end
        end
    endgenerate

    // In-flight count is simply the number of occupied stages.
    always_comb begin
        w_count = 4'd0;
        for (int i = 0; i < LATENCY; i++) begin
            w_count = w_count + {3'd0, w_vld[i]};
        end
    end

    assign pending    = w_count;
    assign data_valid = w_vld[LATENCY-1];
    assign data_out   = w_vld[LATENCY-1] ? w_dat[LATENCY-1] : 16'h0000;

endmodule

// File: tb/tb_mem_fill_responder.sv
// Scoreboard bench for mem_fill_responder: a memory model queues expected returns,
// a monitor on the falling edge pops and compares whenever the DUT presents data.
module tb_mem_fill_responder;

    localparam int L  = 4;
    localparam int AW = 16;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          wr;
    logic [AW-1:0] addr;
    logic [15:0]   data_in;
    logic [15:0]   data_out;
    logic          data_valid;
    logic [3:0]    pending;

    mem_fill_responder #(.LATENCY(L), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr         (wr),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q [$];
    logic [15:0] ref_mem [int];
    exp_t        mdl_e;
    exp_t        mon_e;
    int          edge_cnt = 0;
    int          max_pend = 0;
    int          n_tests  = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    // Reference model: a word array plus a list of (return cycle, data) in issue order.
    always @(posedge clk) begin
        edge_cnt++;
        if (rst_n && enable) begin
            if (wr) begin
                ref_mem[int'(addr[AW-1:1])] = data_in;
            end else begin
                mdl_e.due  = edge_cnt + L - 1;
                mdl_e.data = ref_mem.exists(int'(addr[AW-1:1])) ? ref_mem[int'(addr[AW-1:1])] : 16'hxxxx;
                exp_q.push_back(mdl_e);
            end
        end
    end

    always @(negedge rst_n) exp_q.delete();

    always @(negedge clk) begin
        if (rst_n) begin
            check("pending", {28'd0, pending}, exp_q.size());
            if (int'(pending) > max_pend) max_pend = int'(pending);
            if (data_valid) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_valid: got data_valid=1 data_out=%h, required no return (edge %0d)",
                             data_out, edge_cnt);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ret_cycle", edge_cnt, mon_e.due);
                    check("ret_data", {16'd0, data_out}, {16'd0, mon_e.data});
                end
            end else begin
                check("idle_data_out", {16'd0, data_out}, 32'd0);
                if (exp_q.size() > 0 && exp_q[0].due <= edge_cnt) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL missing_return: got data_valid=0, required return due at edge %0d (edge %0d)",
                             exp_q[0].due, edge_cnt);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic req(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        enable  = en;
        wr      = w;
        addr    = a;
        data_in = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) req(1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
    endtask

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b0;
        wr      = 1'b0;
        addr    = '0;
        data_in = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 128; i++) req(1'b1, 1'b1, 16'(2 * i), 16'($urandom));
        req(1'b1, 1'b1, 16'h0040, 16'hBEEF);
        req(1'b1, 1'b1, 16'h0100, 16'h1111);
        for (int i = 0; i < 8; i++) req(1'b1, 1'b1, 16'h1230 + 16'(2 * i), 16'hA000 + 16'(i));
        idle(2);

        // Asynchronous reset with reads in flight, checked between edges.
        req(1'b1, 1'b0, 16'h0040, 16'h0);
        req(1'b1, 1'b0, 16'h1230, 16'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_data_valid", {31'd0, data_valid}, 32'd0);
        check("rst_data_out", {16'd0, data_out}, 32'd0);
        check("rst_pending", {28'd0, pending}, 32'd0);
        req(1'b1, 1'b0, 16'h0040, 16'h0);
        req(1'b1, 1'b1, 16'h0040, 16'h5555);
        @(negedge clk);
        enable = 1'b0;
        rst_n  = 1'b1;
        idle(L + 2);

        // Single read of the BEEF word.
        req(1'b1, 1'b0, 16'h0040, 16'h0);
        idle(L + 1);

        // Eight-word line fill.
        max_pend = 0;
        for (int i = 0; i < 8; i++) req(1'b1, 1'b0, 16'h1230 + 16'(2 * i), 16'h0);
        idle(L + 2);
        check("burst_peak_pending", max_pend, L);

        // Write after issue must not disturb the in-flight read.
        req(1'b1, 1'b0, 16'h0100, 16'h0);
        req(1'b1, 1'b1, 16'h0100, 16'h2222);
        idle(2);
        req(1'b1, 1'b0, 16'h0100, 16'h0);
        idle(L + 1);

        // Gapped stream, middle read with address bit 0 set.
        req(1'b1, 1'b0, 16'h1230, 16'h0);
        idle(1);
        req(1'b1, 1'b0, 16'h1233, 16'h0);
        req(1'b1, 1'b0, 16'h1234, 16'h0);
        idle(L + 1);

        // Reset after three burst reads; only the post-reset read may return.
        for (int i = 0; i < 3; i++) req(1'b1, 1'b0, 16'h1230 + 16'(2 * i), 16'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        enable = 1'b0;
        rst_n  = 1'b1;
        req(1'b1, 1'b0, 16'h123E, 16'h0);
        idle(L + 2);

        // Random mix of reads, writes and idles over the preloaded window.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       idle(1);
                1:       req(1'b1, 1'b1, 16'($urandom_range(0, 255)) & 16'h00FE, 16'($urandom));
                default: req(1'b1, 1'b0, 16'($urandom_range(0, 255)), 16'($urandom));
            endcase
        end
        idle(L + 2);
        check("drain_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
